// File: rtl/matrix_operand_buffer_if.sv
// Handshake bundle between register decode / compute array and the operand buffer.
// The buffer takes the slave modport; the register decode and consumer side take master.
interface matrix_operand_buffer_if #(
  parameter int ELEM_W = 8,
  parameter int ELEMS  = 9,
  parameter int ROWS   = 4
);
  localparam int ROW_W = ELEM_W * ELEMS;
  localparam int LVL_W = $clog2(ROWS + 1);

  logic              clear;
  logic              load_en;
  logic              valid_input;
  logic [31:0]       PWDATA;
  logic              in_ready;
  logic              load_done;
  logic              out_valid;
  logic              out_ready;
  logic [ROW_W-1:0]  out_data;
  logic [LVL_W-1:0]  level;
  logic              ovf_err;

  modport master (
    output clear, load_en, valid_input, PWDATA, out_ready,
    input  in_ready, load_done, out_valid, out_data, level, ovf_err
  );

  modport slave (
    input  clear, load_en, valid_input, PWDATA, out_ready,
    output in_ready, load_done, out_valid, out_data, level, ovf_err
  );
endinterface

// File: rtl/matrix_operand_buffer.sv
// Packs 32-bit APB words into ELEM_W*ELEMS-bit rows and queues them in a ROWS-deep FIFO.
// Optional sticky overflow flag: define MATRIX_BUF_OVF_STICKY_EN.
module matrix_operand_buffer #(
  parameter int ELEM_W = 8,
  parameter int ELEMS  = 9,
  parameter int ROWS   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  matrix_operand_buffer_if.slave  bus
);
  localparam int ROW_W  = ELEM_W * ELEMS;
  localparam int WPR    = (ROW_W + 31) / 32;
  localparam int LAST_W = ROW_W - 32 * (WPR - 1);
  localparam int PTR_W  = $clog2(ROWS);
  localparam int LVL_W  = $clog2(ROWS + 1);
  localparam int CNT_W  = (WPR > 1) ? $clog2(WPR) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WPR - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(ROWS);

  logic [CNT_W-1:0] word_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [ROW_W-1:0] mem [ROWS];
  logic [ROW_W-1:0] row;

  logic last_word;
  logic in_rdy;
  logic acc;
  logic push;
  logic pop;

  // Only the last word of a row needs FIFO space, so a full FIFO still takes leading words.
  always_comb begin
    last_word = (word_cnt == CNT_LAST);
    in_rdy    = !last_word || (level_q != LVL_FULL);
    acc       = bus.load_en && bus.valid_input && in_rdy && !bus.clear;
    push      = acc && last_word;
    pop       = (level_q != '0) && bus.out_ready && !bus.clear;
  end

  assign bus.in_ready  = in_rdy;
  assign bus.load_done = push;
  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.level     = level_q;

  generate
    if (WPR > 1) begin : g_asm
      localparam int ASM_W = 32 * (WPR - 1);
      logic [ASM_W-1:0] asm_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          asm_q <= '0;
        end else if (bus.clear) begin
          asm_q <= '0;
        end else if (acc && !last_word) begin
          asm_q <= (asm_q << 32) | ASM_W'(bus.PWDATA);
        end
      end

      // Earlier words occupy the MSBs; only the low LAST_W bits of the final word are kept.
      assign row = {asm_q, bus.PWDATA[LAST_W-1:0]};
    end else begin : g_single
      assign row = bus.PWDATA[LAST_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (bus.clear) begin
      word_cnt <= '0;
    end else if (acc) begin
      word_cnt <= last_word ? '0 : word_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= row;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (bus.clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef MATRIX_BUF_OVF_STICKY_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
    end else if (bus.load_en && bus.valid_input && !in_rdy) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf_err = ovf_q;
`else
  assign bus.ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_operand_buffer.sv
// Directed + randomized bench for matrix_operand_buffer against a queue-based row model.
module tb_matrix_operand_buffer;
  localparam int ELEM_W = 8;
  localparam int ELEMS  = 9;
  localparam int ROWS   = 4;
  localparam int ROW_W  = ELEM_W * ELEMS;
  localparam int WPR    = (ROW_W + 31) / 32;
  localparam int LAST_W = ROW_W - 32 * (WPR - 1);

  logic clk = 1'b0;
  logic rst = 1'b0;

  matrix_operand_buffer_if #(.ELEM_W(ELEM_W), .ELEMS(ELEMS), .ROWS(ROWS)) bus ();

  matrix_operand_buffer #(.ELEM_W(ELEM_W), .ELEMS(ELEMS), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  logic [31:0]      part_q[$];
  logic [ROW_W-1:0] fifo_q[$];
  logic             m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] make_row();
    logic [ROW_W-1:0] r;
    r = '0;
    for (int i = 0; i < WPR; i++) begin
      if (i < WPR - 1) r = (r << 32) | ROW_W'(part_q[i]);
      else             r = (r << LAST_W) | ROW_W'(part_q[i][LAST_W-1:0]);
    end
    return r;
  endfunction

  function automatic logic exp_rdy();
    return !((part_q.size() == WPR - 1) && (fifo_q.size() == ROWS));
  endfunction

  task automatic model_reset();
    part_q.delete();
    fifo_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic check_regs();
    chk("level", ROW_W'(bus.level), ROW_W'(fifo_q.size()));
    chk("out_valid", ROW_W'(bus.out_valid), ROW_W'(fifo_q.size() != 0));
    chk("ovf_err", ROW_W'(bus.ovf_err), ROW_W'(m_ovf));
    if (fifo_q.size() != 0) chk("out_data", bus.out_data, fifo_q[0]);
  endtask

  // One clock: drive, check combinational outputs, clock, advance model, check registers.
  task automatic cycle(input logic le, input logic vi, input logic [31:0] d,
                       input logic ordy, input logic clr);
    logic             rdy;
    logic             acc;
    logic             pushrow;
    logic [ROW_W-1:0] r;
    bus.load_en     = le;
    bus.valid_input = vi;
    bus.PWDATA      = d;
    bus.out_ready   = ordy;
    bus.clear       = clr;
    #2;
    rdy = exp_rdy();
    acc = le && vi && rdy && !clr;
    chk("in_ready", ROW_W'(bus.in_ready), ROW_W'(rdy));
    chk("load_done", ROW_W'(bus.load_done), ROW_W'(acc && (part_q.size() == WPR - 1)));
    @(posedge clk);
    #1;
    pushrow = 1'b0;
    r = '0;
    if (clr) begin
      model_reset();
    end else begin
`ifdef MATRIX_BUF_OVF_STICKY_EN
      if (le && vi && !rdy) m_ovf = 1'b1;
`endif
      if (acc) begin
        part_q.push_back(d);
        if (part_q.size() == WPR) begin
          r = make_row();
          part_q.delete();
          pushrow = 1'b1;
        end
      end
      if (ordy && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (pushrow) fifo_q.push_back(r);
    end
    check_regs();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, ROW_W'(bus.in_ready), ROW_W'(1'b1));
    chk({tag, "_load_done"}, ROW_W'(bus.load_done), '0);
    chk({tag, "_level"}, ROW_W'(bus.level), '0);
    chk({tag, "_out_valid"}, ROW_W'(bus.out_valid), '0);
    chk({tag, "_out_data"}, bus.out_data, '0);
    chk({tag, "_ovf_err"}, ROW_W'(bus.ovf_err), '0);
  endtask

  initial begin
    bus.load_en     = 1'b0;
    bus.valid_input = 1'b0;
    bus.PWDATA      = '0;
    bus.out_ready   = 1'b0;
    bus.clear       = 1'b0;

    // Reset values
    #12;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic packing
    cycle(1, 1, 32'h11223344, 0, 0);
    cycle(1, 1, 32'h55667788, 0, 0);
    cycle(1, 1, 32'hAABBCCDD, 0, 0);
    chk("basic_row", bus.out_data, 72'h1122334455667788DD);
    chk("basic_level", ROW_W'(bus.level), ROW_W'(1));
    cycle(0, 0, 0, 0, 1);

    // Partial row held across an idle load window
    cycle(1, 1, 32'h11223344, 0, 0);
    cycle(1, 1, 32'h55667788, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 1, $urandom, 0, 0);
    cycle(1, 1, 32'hAABBCCDD, 0, 0);
    chk("hold_row", bus.out_data, 72'h1122334455667788DD);
    cycle(0, 0, 0, 0, 1);

    // Fill, stall on the last word, overflow offer, pop, resume
    for (int i = 0; i < ROWS * WPR; i++) cycle(1, 1, $urandom, 0, 0);
    cycle(1, 1, $urandom, 0, 0);
    cycle(1, 1, $urandom, 0, 0);
    chk("full_level", ROW_W'(bus.level), ROW_W'(ROWS));
    chk("full_in_ready", ROW_W'(bus.in_ready), '0);
    cycle(1, 1, 32'hDEADBEEF, 0, 0);
`ifdef MATRIX_BUF_OVF_STICKY_EN
    chk("ovf_set", ROW_W'(bus.ovf_err), ROW_W'(1));
`else
    chk("ovf_off", ROW_W'(bus.ovf_err), '0);
`endif
    cycle(0, 0, 0, 1, 0);
    chk("pop_in_ready", ROW_W'(bus.in_ready), ROW_W'(1));
    cycle(1, 1, $urandom, 0, 0);
    chk("refill_level", ROW_W'(bus.level), ROW_W'(ROWS));
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("ovf_cleared", ROW_W'(bus.ovf_err), '0);

    // Simultaneous push and pop at level 2, then FIFO order across pointer wraps
    for (int i = 0; i < 2 * WPR + WPR - 1; i++) cycle(1, 1, $urandom, 0, 0);
    cycle(1, 1, $urandom, 1, 0);
    chk("pushpop_level", ROW_W'(bus.level), ROW_W'(2));
    for (int i = 0; i < 40; i++) cycle(1, 1, $urandom, logic'(i % 2), 0);

    // Clear mid-row, then a fresh row
    cycle(0, 0, 0, 0, 1);
    cycle(1, 1, 32'h99999999, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("clear_level", ROW_W'(bus.level), '0);
    cycle(1, 1, 32'hCAFEF00D, 0, 0);
    cycle(1, 1, 32'h01234567, 0, 0);
    cycle(1, 1, 32'h89ABCDEF, 0, 0);
    chk("clear_row", bus.out_data, 72'hCAFEF00D01234567EF);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0), $urandom,
            logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset mid-drain
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3 * WPR + 1; i++) cycle(1, 1, $urandom, 0, 0);
    cycle(0, 0, 0, 1, 0);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    bus.out_ready = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0), 1'b1, $urandom, logic'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/matrix_operand_buffer.md
# matrix_operand_buffer

Parametrised operand buffer for the matrix unit: packs 32-bit APB write words into rows of `ELEMS` elements of `ELEM_W` bits each, and queues completed rows in a `ROWS`-deep FIFO. The compute array drains the FIFO through a valid/ready handshake. Sits between the APB slave register decode and the systolic/MAC array input; replaces the single-row, fixed 72-bit operand loader.

## Interface
- `ELEM_W`, 8, element width in bits (1..32)
- `ELEMS`, 9, elements per row; `ROW_W = ELEM_W*ELEMS`
- `ROWS`, 4, FIFO depth in rows; power of two, >= 2
- Derived, not overridable:
  - `WPR = ceil(ROW_W/32)`, words per row
  - `LAST_W = ROW_W - 32*(WPR-1)`, bits taken from the last word
- `clk` in 1 — clock, rising edge
- `rst` in 1 — reset, asynchronous, active-low
- `clear` in 1 — synchronous flush; highest priority after reset
- `load_en` in 1 — load window enable from register decode
- `valid_input` in 1 — PWDATA carries a write word this cycle
- `PWDATA` in 32 — write data
- `in_ready` out 1 — a word offered this cycle is accepted
- `load_done` out 1 — one-cycle pulse: the accepted word completed a row
- `out_valid` out 1 — FIFO non-empty
- `out_ready` in 1 — consumer takes head row
- `out_data` out ROW_W — head row
- `level` out `$clog2(ROWS+1)` — rows stored
- `ovf_err` out 1 — sticky overflow flag; see Configuration

## Operation
- Accept: `acc = load_en & valid_input & in_ready & ~clear`.
- Row assembly:
  - `word_cnt` runs 0..WPR-1.
  - On `acc` with `word_cnt < WPR-1`: `asm = {asm, PWDATA}` (shift left by 32); `word_cnt` increments.
  - On `acc` with `word_cnt == WPR-1`: row = `{asm[ROW_W-LAST_W-1:0], PWDATA[LAST_W-1:0]}`. The first word lands in the MSBs; upper `32-LAST_W` bits of the last word are ignored.
  - On completing a row: the row is pushed into the FIFO, `word_cnt` returns to 0, and `load_done` = 1.
  - If `WPR == 1`, every accepted word is a complete row.
- `load_en` or `valid_input` low: `asm` and `word_cnt` hold; a partial row persists across load windows.
- `in_ready = (word_cnt != WPR-1) | (level != ROWS)`. No combinational path from `out_ready`.
- Pop: `out_valid & out_ready` advances the read pointer. Push and pop in the same cycle are both performed; `level` is unchanged.
- `out_data` is the register-array entry at the read pointer. It is defined only while `out_valid`.
- Pointers are `$clog2(ROWS)` bits and wrap naturally. Full/empty are derived from `level`.
- `clear`:
  - Resets `word_cnt`, `asm`, the pointers, `level` and `ovf_err` to 0.
  - Any pop or push requested in that cycle is discarded.
  - `load_done` = 0.
- `load_done` is combinational (`acc & word_cnt==WPR-1`). Every other output is registered or derived from registers.

## Timing
- Reset values:
  - `level` = 0, `out_valid` = 0, `ovf_err` = 0, `out_data` = 0 (array cleared), `word_cnt` = 0.
  - `in_ready` = 1.
  - `load_done` = 0.
- Last word accepted at edge T: `out_valid` = 1 and `out_data` valid from T onward (the same edge writes the entry); `level` increments at T.
- Throughput: one word per cycle; one row every WPR cycles with no stalls.
- Full FIFO: words below the last word are still accepted. The last word stalls (`in_ready` = 0) until a pop registers; `in_ready` rises the cycle after the popping edge.
- Reset mid-row or mid-drain: all state is lost immediately and asynchronously; no row is emitted.

## Configuration
- `MATRIX_BUF_OVF_STICKY_EN` defined:
  - `ovf_err` sets on any cycle with `load_en & valid_input & ~in_ready & ~clear`.
  - It holds until `clear` or reset.
  - The offered word is dropped in either configuration.
- Undefined: `ovf_err` is tied to 0 and no flag register is synthesised.

## Test plan
- Basic packing: defaults; write 0x11223344, 0x55667788, 0xAABBCCDD with `out_ready` = 0 → `load_done` high only on the third word; `out_data` = 72'h1122334455667788DD; `level` = 1.
- Partial hold: two words, then `load_en` = 0 for 5 cycles, then the third word → same row as the basic-packing case; `load_done` is not asserted early.
- Fill and stall: 4 rows with `out_ready` = 0, then two words of a fifth row → `level` = 4 and `in_ready` = 0. Pop one row → `in_ready` = 1 the next cycle; the last word is accepted and `level` returns to 4.
- Simultaneous push/pop: `level` = 2 and `out_ready` = 1 on the last-word cycle → `level` stays 2; FIFO order is preserved across the pointer wrap after more than 8 rows.
- Clear and reset mid-row: 1 word, then `clear` → `word_cnt` = 0 and `level` = 0; the next 3 words form a fresh row. Assert `rst` low mid-drain → all outputs go to their reset values asynchronously.
- Overflow, macro on: offer the last word while full → `ovf_err` = 1 and stays 1 until `clear`. Macro off → `ovf_err` stays 0.
